// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - memory-mapped autonomous LED sequencer; optional PWM dimming with LED_PWM_EN
module led_seq_ctrl #(
    parameter int NUM_LEDS     = 4,
    parameter int RESET_PERIOD = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_pulse
);
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_MODE   = 3'd1;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_BRIGHT = 3'd4;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_ROTL   = 2'd1;
    localparam logic [1:0] MODE_ROTR   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_LEDS-1:0] pattern;
    logic [NUM_LEDS-1:0] pattern_rot;
    logic [NUM_LEDS-1:0] seq_leds;
    logic [1:0]          mode;
    logic [31:0]         period;
    logic [31:0]         period_last;
    logic [31:0]         cnt;
    logic                phase;
    logic [15:0]         step_count;
    logic [2:0]          reg_sel;
    logic                wr_data;
    logic                wr_mode;
    logic                wr_period;
    logic                cfg_write;
    logic                rd_en;
    logic                step;
    logic                running;
    logic [31:0]         rd_value;
    logic                unused_addr_bits;

    assign reg_sel          = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];
    assign rd_en            = sel & ~we;
    assign wr_data          = sel & we & (reg_sel == REG_DATA);
    assign wr_mode          = sel & we & (reg_sel == REG_MODE);
    assign wr_period        = sel & we & (reg_sel == REG_PERIOD);
    // Any configuration write restarts the step timer and suppresses a coincident step.
    assign cfg_write        = wr_data | wr_mode | wr_period;
    // A period of zero behaves like a period of one.
    assign period_last      = (period == 32'd0) ? 32'd0 : period - 32'd1;
    assign step             = (state == RUN) && (cnt == period_last) && !cfg_write;

    // Rotated pattern for the current mode; other modes keep the pattern.
    always_comb begin
        pattern_rot = pattern;
        case (mode)
            MODE_ROTL: pattern_rot = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
            MODE_ROTR: pattern_rot = {pattern[0], pattern[NUM_LEDS-1:1]};
            default:   pattern_rot = pattern;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: only MODE writes move between IDLE and RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_mode && (wdata[1:0] != MODE_DIRECT)) state_next = RUN;
            RUN:     if (wr_mode && (wdata[1:0] == MODE_DIRECT)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: running flag and the unmasked LED pattern.
    always_comb begin
        running  = (state == RUN);
        seq_leds = pattern;
        if (running && (mode == MODE_BLINK) && phase) begin
            seq_leds = '0;
        end
    end

    // Software-visible registers; a DATA write takes priority over a rotate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
            mode    <= MODE_DIRECT;
            period  <= 32'(RESET_PERIOD);
        end else begin
            if (wr_data) begin
                pattern <= wdata[NUM_LEDS-1:0];
            end else if (step) begin
                pattern <= pattern_rot;
            end
            if (wr_mode) begin
                mode <= wdata[1:0];
            end
            if (wr_period) begin
                period <= wdata;
            end
        end
    end

    // Step timer, blink phase and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 32'd0;
            phase      <= 1'b0;
            step_count <= 16'd0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step;
            if (cfg_write || (state != RUN) || step) begin
                cnt <= 32'd0;
            end else begin
                cnt <= cnt + 32'd1;
            end
            if (cfg_write) begin
                phase <= 1'b0;
            end else if (step && (mode == MODE_BLINK)) begin
                phase <= ~phase;
            end
            if (step) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] bright;
    logic [7:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_cnt < bright);

    // Brightness register and free-running PWM counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright  <= 8'hFF;
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (sel && we && (reg_sel == REG_BRIGHT)) begin
                bright <= wdata[7:0];
            end
        end
    end

    // LED drive gated by the PWM duty cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else begin
            leds <= seq_leds & {NUM_LEDS{pwm_on}};
        end
    end
`else
    // LED drive straight from the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else begin
            leds <= seq_leds;
        end
    end
`endif

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_value = 32'd0;
        case (reg_sel)
            REG_DATA:   rd_value = {{(32-NUM_LEDS){1'b0}}, pattern};
            REG_MODE:   rd_value = {30'd0, mode};
            REG_PERIOD: rd_value = period;
            REG_STATUS: rd_value = {step_count, 15'd0, running};
`ifdef LED_PWM_EN
            REG_BRIGHT: rd_value = {24'd0, bright};
`endif
            default:    rd_value = 32'd0;
        endcase
    end

    // Registered read data, updated only on a read access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (rd_en) begin
            rdata <= rd_value;
        end
    end

endmodule
